// File: rtl/float_to_int_pipe_pkg.sv
// Shared FPU definitions: rounding-mode encodings, exponent constants and the
// per-stage payload structs of the float-to-int conversion pipeline.
package float_to_int_pipe_pkg;

  // FCSR rounding modes, the same 2-bit encoding the FP adder uses
  typedef enum logic [1:0] {
    RM_RNE = 2'b00,  // nearest, ties to even
    RM_RZ  = 2'b01,  // toward zero
    RM_RP  = 2'b10,  // toward +inf
    RM_RM  = 2'b11   // toward -inf
  } rm_e;

  localparam int          FP_BIAS           = 127;
  localparam int          FP_EXP_MAX        = 255;
  localparam logic [31:0] FP_INVALID_RESULT = 32'h7FFF_FFFF;

  // -2^31 is the only input with unbiased exponent 31 that still fits
  localparam logic [31:0] MIN_INT_FLOAT = 32'hCF00_0000;
  localparam logic [31:0] MIN_INT_VALUE = 32'h8000_0000;

  // Shape of the operand as decided by the unpack stage; it tells the shift
  // stage which way (if at all) to move the significand.
  typedef enum logic [2:0] {
    CLS_ZERO    = 3'd0,  // +0 / -0
    CLS_TINY    = 3'd1,  // denormal or e <= -2: only sticky survives
    CLS_HALF    = 3'd2,  // e == -1: hidden bit becomes the guard bit
    CLS_RSHIFT  = 3'd3,  // e in 0..23
    CLS_LSHIFT  = 3'd4,  // e in 24..30
    CLS_INVALID = 3'd5,  // NaN, infinity or out of range
    CLS_MININT  = 3'd6   // exactly -2^31
  } cls_e;

  // Unpack -> shift register payload
  typedef struct packed {
    logic        sign;
    rm_e         rm;
    cls_e        cls;
    logic [4:0]  e5;    // low bits of unbiased exponent, meaningful for 0..30
    logic [23:0] sig;   // {hidden, frac}
  } s1_t;

  // Shift -> round register payload
  typedef struct packed {
    logic        sign;
    rm_e         rm;
    logic        invalid;
    logic        min_int;
    logic [30:0] mag;
    logic        g;
    logic        s;
  } s2_t;

endpackage

// File: rtl/float_to_int_pipe_if.sv
// Request/result bundle of the float-to-int converter.
// Handshake: an op is accepted on a rising edge where en && in_valid. A result
// is presented while out_valid is high and is replaced only on an edge where
// en is high; there is no ready signal, en is the sole back-pressure.
interface float_to_int_pipe_if;
  logic        in_valid;
  logic [31:0] a;
  logic [1:0]  rm;
  logic        out_valid;
  logic [31:0] d;
  logic        invalid;
  logic        inexact;

  modport master (
    output in_valid, a, rm,
    input  out_valid, d, invalid, inexact
  );

  modport slave (
    input  in_valid, a, rm,
    output out_valid, d, invalid, inexact
  );
endinterface

// File: rtl/float_to_int_round.sv
// Final-stage combinational logic: rounding increment, negation and
// substitution of the invalid / -2^31 results, plus flag generation.
module float_to_int_round
  import float_to_int_pipe_pkg::*;
#(
  parameter logic [31:0] INVALID_RESULT = FP_INVALID_RESULT
) (
  input  logic        sign_i,
  input  rm_e         rm_i,
  input  logic        invalid_i,
  input  logic        min_int_i,
  input  logic [30:0] mag_i,
  input  logic        g_i,
  input  logic        s_i,
  output logic [31:0] d_o,
  output logic        invalid_o,
  output logic        inexact_o
);

  logic        inc;
  logic [31:0] rounded;

  // Round the magnitude, apply the sign, then override for special inputs.
  // The magnitude is below 2^24 whenever g/s can be set, so +1 never carries
  // into the sign bit.
  always_comb begin
    inc = 1'b0;
    case (rm_i)
      RM_RNE: inc = g_i & (s_i | mag_i[0]);
      RM_RZ:  inc = 1'b0;
      RM_RP:  inc = ~sign_i & (g_i | s_i);
      RM_RM:  inc = sign_i & (g_i | s_i);
    endcase
    rounded   = {1'b0, mag_i} + {31'b0, inc};
    // negating a zero magnitude yields zero, so no negative zero escapes
    d_o       = sign_i ? (~rounded + 32'd1) : rounded;
    invalid_o = 1'b0;
    inexact_o = g_i | s_i;
    if (invalid_i) begin
      d_o       = INVALID_RESULT;
      invalid_o = 1'b1;
      inexact_o = 1'b0;
    end else if (min_int_i) begin
      d_o       = MIN_INT_VALUE;
      inexact_o = 1'b0;
    end
  end

endmodule

// File: rtl/float_to_int_pipe.sv
// Three-stage single-precision float to signed 32-bit integer converter:
// unpack/classify -> shift -> round/negate/saturate, one op per cycle,
// stalled as a whole by en.
module float_to_int_pipe
  import float_to_int_pipe_pkg::*;
#(
  parameter logic [31:0] INVALID_RESULT = FP_INVALID_RESULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  float_to_int_pipe_if.slave bus
);

  // stage 1
  logic [7:0]  exp_f;
  logic [22:0] frac;
  logic [8:0]  e9;
  s1_t         s1_d, s1_q;
  logic        s1_valid_q;

  // stage 2
  logic [4:0]  shr_amt;
  logic [2:0]  shl_amt;
  logic [47:0] wide;
  s2_t         s2_d, s2_q;
  logic        s2_valid_q;

  // stage 3 / outputs
  logic [31:0] rnd_d;
  logic        rnd_invalid;
  logic        rnd_inexact;
  logic        out_valid_q;
  logic [31:0] d_q;
  logic        invalid_q;
  logic        inexact_q;

  // S1: split the IEEE word and decide how the significand must be moved
  always_comb begin
    exp_f   = bus.a[30:23];
    frac    = bus.a[22:0];
    e9      = {1'b0, exp_f} - 9'(FP_BIAS);
    s1_d      = '0;
    s1_d.sign = bus.a[31];
    s1_d.rm   = rm_e'(bus.rm);
    s1_d.sig  = {1'b1, frac};
    s1_d.e5   = e9[4:0];
    if (exp_f == 8'(FP_EXP_MAX)) begin
      s1_d.cls = CLS_INVALID;
    end else if (bus.a == MIN_INT_FLOAT) begin
      s1_d.cls = CLS_MININT;
    end else if (exp_f == 8'd0) begin
      s1_d.cls = (frac == 23'd0) ? CLS_ZERO : CLS_TINY;
    end else if ($signed(e9) >= 9'sd31) begin
      s1_d.cls = CLS_INVALID;
    end else if ($signed(e9) >= 9'sd24) begin
      s1_d.cls = CLS_LSHIFT;
    end else if ($signed(e9) >= 9'sd0) begin
      s1_d.cls = CLS_RSHIFT;
    end else if ($signed(e9) == -9'sd1) begin
      s1_d.cls = CLS_HALF;
    end else begin
      s1_d.cls = CLS_TINY;
    end
  end

  // S1 -> S2 register; reset beats en so in-flight ops are dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_q       <= '0;
    end else if (en) begin
      s1_valid_q <= bus.in_valid;
      s1_q       <= s1_d;
    end
  end

  // S2: denormalise the significand into a 31-bit magnitude plus guard/sticky
  always_comb begin
    s2_d         = '0;
    s2_d.sign    = s1_q.sign;
    s2_d.rm      = s1_q.rm;
    s2_d.invalid = (s1_q.cls == CLS_INVALID);
    s2_d.min_int = (s1_q.cls == CLS_MININT);
    shr_amt      = 5'd23 - s1_q.e5;
    shl_amt      = 3'(s1_q.e5 - 5'd23);
    // integer part lands in [47:24], the bits shifted out in [23:0]
    wide         = {s1_q.sig, 24'b0} >> shr_amt;
    case (s1_q.cls)
      CLS_RSHIFT: begin
        s2_d.mag = {7'b0, wide[47:24]};
        s2_d.g   = wide[23];
        s2_d.s   = |wide[22:0];
      end
      CLS_LSHIFT: begin
        s2_d.mag = {7'b0, s1_q.sig} << shl_amt;
      end
      CLS_HALF: begin
        s2_d.g = 1'b1;
        s2_d.s = |s1_q.sig[22:0];
      end
      CLS_TINY: begin
        s2_d.s = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // S2 -> S3 register
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      s2_q       <= '0;
    end else if (en) begin
      s2_valid_q <= s1_valid_q;
      s2_q       <= s2_d;
    end
  end

  float_to_int_round #(
    .INVALID_RESULT (INVALID_RESULT)
  ) u_round (
    .sign_i    (s2_q.sign),
    .rm_i      (s2_q.rm),
    .invalid_i (s2_q.invalid),
    .min_int_i (s2_q.min_int),
    .mag_i     (s2_q.mag),
    .g_i       (s2_q.g),
    .s_i       (s2_q.s),
    .d_o       (rnd_d),
    .invalid_o (rnd_invalid),
    .inexact_o (rnd_inexact)
  );

  // Output register: bubbles clear out_valid but leave the last result visible
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      d_q         <= '0;
      invalid_q   <= 1'b0;
      inexact_q   <= 1'b0;
    end else if (en) begin
      out_valid_q <= s2_valid_q;
      if (s2_valid_q) begin
        d_q       <= rnd_d;
        invalid_q <= rnd_invalid;
        inexact_q <= rnd_inexact;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.d         = d_q;
  assign bus.invalid   = invalid_q;
  assign bus.inexact   = inexact_q;

endmodule

// File: tb/tb_float_to_int_pipe.sv
// Bench for float_to_int_pipe: directed vectors, latency, stall, reset in
// flight and a randomized stream against a rational-arithmetic model.
module tb_float_to_int_pipe;

  localparam logic [31:0] INV = 32'h7FFF_FFFF;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  logic en;
  always #5 clk = ~clk;

  float_to_int_pipe_if bus();

  float_to_int_pipe dut (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // expected / observed {invalid, inexact, d}
  logic [33:0] exp_q[$];
  logic [33:0] got_q[$];
  int          got_cyc_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // monitor: a new result appears after an edge where en was high
  initial begin
    bit s_en, s_rst;
    forever begin
      @(posedge clk);
      s_en  = en;
      s_rst = rst;
      #1;
      if (!s_rst && s_en && bus.out_valid === 1'b1) begin
        got_q.push_back({bus.invalid, bus.inexact, bus.d});
        got_cyc_q.push_back(cyc);
      end
    end
  end

  // ---------------- reference model ----------------
  // value = sig * 2^(exp-150); integer part and remainder are compared with
  // one half using plain integer arithmetic.
  function automatic logic [33:0] ref_model(input logic [31:0] x, input logic [1:0] mode);
    int     ex, sh, cmp;
    longint sig, ip, rem, half, mag;
    bit     neg, nz, up;
    neg = x[31];
    ex  = int'(x[30:23]);
    if (ex == 255) return {2'b10, INV};
    if (x == 32'hCF00_0000) return {2'b00, 32'h8000_0000};
    if (ex >= 158) return {2'b10, INV};
    ip  = 0;
    nz  = 0;
    cmp = -1;
    if (ex == 0) begin
      nz = (x[22:0] != 0);
    end else begin
      sig = longint'({1'b1, x[22:0]});
      sh  = ex - 150;
      if (sh >= 0) begin
        ip = sig << sh;
      end else if (-sh > 40) begin
        nz = 1;
      end else begin
        ip   = sig >> (-sh);
        rem  = sig - (ip << (-sh));
        half = longint'(1) << (-sh - 1);
        nz   = (rem != 0);
        cmp  = (rem > half) ? 1 : ((rem == half) ? 0 : -1);
      end
    end
    case (mode)
      2'd0:    up = nz && (cmp > 0 || (cmp == 0 && ip[0]));
      2'd1:    up = 0;
      2'd2:    up = nz && !neg;
      default: up = nz && neg;
    endcase
    mag = ip + longint'(up);
    return {1'b0, nz, 32'(neg ? -mag : mag)};
  endfunction

  function automatic logic [31:0] gen_float();
    int          pick;
    logic [31:0] x;
    pick = $urandom_range(0, 9);
    x    = $urandom;
    case (pick)
      0: x[30:23] = 8'hFF;
      1: begin x[30:23] = 8'h00; if ($urandom_range(0, 1) == 0) x[22:0] = '0; end
      2: x[30:23] = 8'($urandom_range(156, 159));
      3: begin x[30:23] = 8'($urandom_range(125, 150)); x[12:0] = '0; end
      4: ;
      default: x[30:23] = 8'($urandom_range(110, 160));
    endcase
    return x;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_op(input logic [31:0] x, input logic [1:0] mode);
    @(negedge clk);
    en           = 1'b1;
    bus.in_valid = 1'b1;
    bus.a        = x;
    bus.rm       = mode;
  endtask

  // when en is low, present garbage with in_valid high: it must be ignored
  task automatic drive_idle(input int n, input logic en_val);
    repeat (n) begin
      @(negedge clk);
      en           = en_val;
      bus.in_valid = ~en_val;
      bus.a        = $urandom;
      bus.rm       = 2'($urandom);
    end
  endtask

  task automatic wait_results(input int budget);
    int n;
    n = 0;
    while (got_q.size() < exp_q.size() && n < budget) begin
      @(negedge clk);
      en           = 1'b1;
      bus.in_valid = 1'b0;
      n++;
    end
    drive_idle(4, 1'b1);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [34:0] obs;
    rst          = 1'b1;
    en           = 1'b0;
    bus.in_valid = 1'b0;
    bus.a        = '0;
    bus.rm       = '0;
    repeat (3) @(negedge clk);
    obs = {bus.out_valid, bus.invalid, bus.inexact, bus.d};
    checks++;
    if (obs !== 35'd0) begin
      errors++;
      $display("FAIL reset_outputs got %h exp %h", obs, 35'd0);
    end
    rst = 1'b0;
    en  = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle out_valid got %b exp 0", bus.out_valid);
    end
  endtask

  task automatic test_directed();
    // {a, rm, invalid, inexact, d}
    logic [67:0] tbl [22] = '{
      {32'h3FC0_0000, 2'd0, 1'b0, 1'b1, 32'h0000_0002},
      {32'h3FC0_0000, 2'd1, 1'b0, 1'b1, 32'h0000_0001},
      {32'h4020_0000, 2'd0, 1'b0, 1'b1, 32'h0000_0002},
      {32'hC020_0000, 2'd3, 1'b0, 1'b1, 32'hFFFF_FFFD},
      {32'h7FC0_0000, 2'd0, 1'b1, 1'b0, 32'h7FFF_FFFF},
      {32'h4F00_0000, 2'd0, 1'b1, 1'b0, 32'h7FFF_FFFF},
      {32'hCF00_0000, 2'd0, 1'b0, 1'b0, 32'h8000_0000},
      {32'h0000_0001, 2'd2, 1'b0, 1'b1, 32'h0000_0001},
      {32'h0000_0001, 2'd0, 1'b0, 1'b1, 32'h0000_0000},
      {32'h8000_0000, 2'd0, 1'b0, 1'b0, 32'h0000_0000},
      {32'hBE99_999A, 2'd0, 1'b0, 1'b1, 32'h0000_0000},
      {32'h3F00_0000, 2'd0, 1'b0, 1'b1, 32'h0000_0000},
      {32'h3F00_0000, 2'd2, 1'b0, 1'b1, 32'h0000_0001},
      {32'hBF40_0000, 2'd1, 1'b0, 1'b1, 32'h0000_0000},
      {32'hBF40_0000, 2'd3, 1'b0, 1'b1, 32'hFFFF_FFFF},
      {32'h4EFF_FFFF, 2'd0, 1'b0, 1'b0, 32'h7FFF_FF80},
      {32'hCF00_0001, 2'd0, 1'b1, 1'b0, 32'h7FFF_FFFF},
      {32'h4B00_0001, 2'd1, 1'b0, 1'b0, 32'h0080_0001},
      {32'hFF80_0000, 2'd1, 1'b1, 1'b0, 32'h7FFF_FFFF},
      {32'h3FE0_0000, 2'd0, 1'b0, 1'b1, 32'h0000_0002},
      {32'h3F80_0000, 2'd0, 1'b0, 1'b0, 32'h0000_0001},
      {32'hC060_0000, 2'd0, 1'b0, 1'b1, 32'hFFFF_FFFC}
    };
    logic [67:0] t;
    logic [33:0] e, g;
    for (int i = 0; i < 22; i++) begin
      t = tbl[i];
      drive_op(t[67:36], t[35:34]);
      exp_q.push_back(t[33:0]);
    end
    wait_results(100);
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      checks++;
      if (got_q.size() == 0) begin
        errors++;
        $display("FAIL directed_%0d missing result exp %h", i, e);
      end else begin
        g = got_q.pop_front();
        void'(got_cyc_q.pop_front());
        if (g !== e) begin
          errors++;
          $display("FAIL directed_%0d got %h exp %h", i, g, e);
        end
      end
    end
    checks++;
    if (got_q.size() != 0) begin
      errors++;
      $display("FAIL directed_extra got %0d extra results exp 0", got_q.size());
    end
    got_q.delete();
    got_cyc_q.delete();
  endtask

  task automatic test_latency();
    logic [34:0] obs;
    drive_op(32'h3FC0_0000, 2'd0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      obs = {bus.out_valid, bus.invalid, bus.inexact, bus.d};
      checks++;
      if (k < 2 && bus.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL latency_early edge %0d out_valid got %b exp 0", k, bus.out_valid);
      end else if (k == 2 && obs !== {1'b1, 2'b01, 32'd2}) begin
        errors++;
        $display("FAIL latency_result got %h exp %h", obs, {1'b1, 2'b01, 32'd2});
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
    end
    drive_idle(3, 1'b1);
    got_q.delete();
    got_cyc_q.delete();
  endtask

  task automatic test_stall();
    logic [31:0] va [4];
    logic [1:0]  vr [4];
    logic [33:0] e0, e, g;
    logic [34:0] obs;
    int          c0, ecyc, gcyc;
    for (int i = 0; i < 4; i++) begin
      va[i] = gen_float();
      vr[i] = 2'($urandom);
      exp_q.push_back(ref_model(va[i], vr[i]));
    end
    e0 = ref_model(va[0], vr[0]);
    @(negedge clk);
    c0 = cyc + 1;
    en = 1'b1; bus.in_valid = 1'b1; bus.a = va[0]; bus.rm = vr[0];
    drive_op(va[1], vr[1]);
    drive_op(va[2], vr[2]);
    // two stalled edges with op3 already on the bus
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      en = 1'b0; bus.in_valid = 1'b1; bus.a = va[3]; bus.rm = vr[3];
      @(posedge clk);
      #1;
      obs = {bus.out_valid, bus.invalid, bus.inexact, bus.d};
      checks++;
      if (obs !== {1'b1, e0}) begin
        errors++;
        $display("FAIL stall_freeze_%0d got %h exp %h", k, obs, {1'b1, e0});
      end
    end
    @(negedge clk);
    en = 1'b1;
    wait_results(50);
    for (int i = 0; exp_q.size() > 0; i++) begin
      e    = exp_q.pop_front();
      ecyc = c0 + ((i == 0) ? 2 : (i + 4));
      checks++;
      if (got_q.size() == 0) begin
        errors++;
        $display("FAIL stall_%0d missing result exp %h", i, e);
      end else begin
        g    = got_q.pop_front();
        gcyc = got_cyc_q.pop_front();
        if (g !== e || gcyc != ecyc) begin
          errors++;
          $display("FAIL stall_%0d got %h at cycle %0d exp %h at cycle %0d", i, g, gcyc, e, ecyc);
        end
      end
    end
    checks++;
    if (got_q.size() != 0) begin
      errors++;
      $display("FAIL stall_extra got %0d extra results exp 0", got_q.size());
    end
    got_q.delete();
    got_cyc_q.delete();
  endtask

  task automatic test_reset_flight();
    logic [34:0] obs;
    logic [33:0] e, g;
    drive_op(32'h4020_0000, 2'd0);
    drive_op(32'hC020_0000, 2'd3);
    @(negedge clk);
    rst = 1'b1; bus.in_valid = 1'b1; bus.a = 32'h3FC0_0000; bus.rm = 2'd0;
    @(posedge clk);
    #1;
    obs = {bus.out_valid, bus.invalid, bus.inexact, bus.d};
    checks++;
    if (obs !== 35'd0) begin
      errors++;
      $display("FAIL rst_flight_outputs got %h exp %h", obs, 35'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    drive_idle(6, 1'b1);
    checks++;
    if (got_q.size() != 0) begin
      errors++;
      $display("FAIL rst_flight_stale got %0d results exp 0", got_q.size());
    end
    got_q.delete();
    got_cyc_q.delete();
    // the pipe still works after the flush
    drive_op(32'hC060_0000, 2'd1);
    exp_q.push_back({2'b01, 32'hFFFF_FFFD});
    wait_results(20);
    e = exp_q.pop_front();
    checks++;
    if (got_q.size() == 0) begin
      errors++;
      $display("FAIL rst_recover missing result exp %h", e);
    end else begin
      g = got_q.pop_front();
      if (g !== e) begin
        errors++;
        $display("FAIL rst_recover got %h exp %h", g, e);
      end
    end
    got_q.delete();
    got_cyc_q.delete();
  endtask

  task automatic test_random();
    logic [31:0] x;
    logic [1:0]  m;
    logic [33:0] e, g;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        drive_idle($urandom_range(1, 2), 1'($urandom_range(0, 1)));
      end else begin
        x = gen_float();
        m = 2'($urandom);
        drive_op(x, m);
        exp_q.push_back(ref_model(x, m));
      end
    end
    wait_results(200);
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      checks++;
      if (got_q.size() == 0) begin
        errors++;
        $display("FAIL random_%0d missing result exp %h", i, e);
      end else begin
        g = got_q.pop_front();
        void'(got_cyc_q.pop_front());
        if (g !== e) begin
          errors++;
          $display("FAIL random_%0d got %h exp %h", i, g, e);
        end
      end
    end
    checks++;
    if (got_q.size() != 0) begin
      errors++;
      $display("FAIL random_extra got %0d extra results exp 0", got_q.size());
    end
    got_q.delete();
    got_cyc_q.delete();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_directed();
    test_latency();
    test_stall();
    test_reset_flight();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/float_to_int_pipe.md
Name: float_to_int_pipe

Overview:
- Three-stage pipelined single-precision float to signed 32-bit integer converter (cvt.w.s / trunc/round/ceil/floor.w.s).
- Performs the reverse of the FP adder's pack/normalise path: unpacks an IEEE-754 word, denormalises the significand into an integer and rounds under the FCSR rounding mode.
- Sits beside the FP adder in the FPU execute slot and shares the same en stall and 2-bit rm encoding.

Parameters:
- INVALID_RESULT, 32'h7FFF_FFFF, value written on NaN, infinity or out-of-range input.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- en  in  1  pipeline advance; 0 freezes every stage register
- in_valid  in  1  a and rm carry a conversion this cycle
- a  in  32  IEEE-754 single input
- rm  in  2  rounding mode: 00 nearest-even, 01 toward zero, 10 toward +inf, 11 toward -inf
- out_valid  out  1  d and flags are valid
- d  out  32  signed two's-complement result
- invalid  out  1  NaN, infinity or overflow input
- inexact  out  1  discarded nonzero fraction (cleared when invalid)

Behaviour:
- Reset: all stage valid bits = 0; out_valid = 0, d = 0, invalid = 0, inexact = 0. Reset takes priority over en, so reset mid-flight discards every in-flight op.
- Pipeline: S1 unpack/classify -> reg -> S2 shift -> reg -> S3 round/negate/saturate -> output reg.
- Latency: exactly 3 cycles with en = 1. Throughput: 1 op per cycle. No back-pressure beyond en.
- en = 0 holds all registers and outputs unchanged, including out_valid. in_valid is ignored while en = 0.
- Bubbles (in_valid = 0) propagate as valid = 0. The data fields of a bubble are don't-care, but d and the flags keep their last value.
- S1 computes sign, e = exp - 127 and sig = {1, frac} (24 bits). Classification:
  - exp = 255 -> special (NaN or infinity).
  - exp = 0 -> zero or denormal. Treat as magnitude 0 with sticky = (frac != 0).
  - e >= 31 -> overflow, except a = 32'hCF00_0000 (-2^31), which is exact.
  - e < 0 -> integer part 0, sticky set.
- S2 shifting, producing a 31-bit integer magnitude, guard bit g and sticky s:
  - e in 0..23: magnitude = sig >> (23 - e); g = first bit shifted out; s = OR of the remaining shifted-out bits.
  - e in 24..30: magnitude = sig << (e - 23); g = s = 0.
  - e = -1: g = 1 (hidden bit), s = (frac != 0).
  - e <= -2 or denormal: g = 0, s = 1 (s = 0 for zero).
- S3 increment rules:
  - rm = 00: increment when g & (s | lsb).
  - rm = 01: never increment.
  - rm = 10: increment when !sign & (g | s).
  - rm = 11: increment when sign & (g | s).
- S3 output: negate the rounded magnitude when sign = 1. inexact = g | s.
- Rounding cannot overflow: for e <= 23 the magnitude is below 2^24.
- Special or overflow: d = INVALID_RESULT, invalid = 1, inexact = 0.
- Zero of either sign: d = 0, no flags.
- Sign of zero results: -0.3 under rm = 00 gives d = 0 (no negative zero).

Decomposition:
- Shared FPU package holds:
  - rm encodings RM_RNE, RM_RZ, RM_RP, RM_RM;
  - the constants FP_BIAS = 127 and FP_EXP_MAX = 255;
  - INVALID_RESULT default.
- One sub-module, float_to_int_round: combinational S3 logic (increment decision, negate, saturate, flag generation). The S1/S2 logic and the pipeline registers stay in the top module.

Test Plan:
- a = 3FC0_0000 (1.5), rm = 00 -> after 3 cycles d = 2, inexact = 1. The same input with rm = 01 gives d = 1.
- a = 4020_0000 (2.5), rm = 00 -> d = 2 (tie to even), inexact = 1. a = C020_0000 (-2.5), rm = 11 -> d = FFFF_FFFD (-3).
- a = 7FC0_0000 (NaN) and a = 4F00_0000 (2^31) -> d = 7FFF_FFFF, invalid = 1, inexact = 0. a = CF00_0000 -> d = 8000_0000, no flags.
- a = 0000_0001 (denormal): rm = 10 -> d = 1, inexact = 1; rm = 00 -> d = 0, inexact = 1. a = 8000_0000 -> d = 0, no flags.
- Back-to-back stream of 4 ops, with en = 0 for 2 cycles mid-stream -> results emerge in order; d, flags and out_valid are frozen during the stall; the stall adds exactly 2 cycles of latency.
- Assert rst for 1 cycle while 3 ops are in flight -> out_valid = 0 the next cycle, and no stale result ever appears.
